// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, credit-limited imem requests and prefetch FIFO feeding IF/ID
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazard_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        bubble_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];

  logic [CW:0] credit_used;
  logic        accept, resp, push, pop;

  // In-flight requests reserve FIFO slots, so a push can never find the FIFO full.
  assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign imem_req_o  = !rst_i && !flush_i && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr_o = fetch_pc_q;

  assign accept = imem_req_o && imem_ready_i;
  assign resp   = imem_valid_i && (inflight_q != '0);
  assign push   = resp && (drop_cnt_q == '0) && !flush_i;
  assign pop    = !hazard_i && !flush_i && (fifo_cnt_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    fifo_cnt_d = fifo_cnt_q;
    drop_cnt_d = drop_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    inflight_d = inflight_q + CW'(accept) - CW'(resp);
    if (flush_i) begin
      fetch_pc_d = {target_i[31:2], 2'b00};
      resp_pc_d  = {target_i[31:2], 2'b00};
      fifo_cnt_d = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_cnt_d = inflight_q - CW'(resp);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + AW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      fifo_cnt_q <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      fifo_cnt_q <= fifo_cnt_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]    <= resp_pc_q;
        instr_mem_q[wr_ptr_q] <= imem_data_i;
      end
    end
  end

  // Empty FIFO presents the same NOP the IF/ID register loads on flush.
  assign bubble_o = (fifo_cnt_q == '0);
  assign pc_o     = bubble_o ? 32'h0 : pc_mem_q[rd_ptr_q];
  assign instr_o  = bubble_o ? 32'h0 : instr_mem_q[rd_ptr_q];

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(imem_valid_i && (inflight_q == '0)))
        else $error("imem response with no request in flight");
      assert (!(push && !pop && (fifo_cnt_q == CW'(DEPTH))))
        else $error("prefetch fifo overflow");
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a queue-based memory model
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data = '0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        bubble;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .hazard_i    (hazard),
    .flush_i     (flush),
    .target_i    (target),
    .imem_req_o  (imem_req),
    .imem_addr_o (imem_addr),
    .imem_ready_i(imem_ready),
    .imem_valid_i(imem_valid),
    .imem_data_i (imem_data),
    .pc_o        (pc),
    .instr_o     (instr),
    .bubble_o    (bubble)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        pend_q[$];
  ent_t        sb_q[$];
  logic [31:0] next_pc = RESET_PC;
  int          epoch = 0;
  int          cyc = 0;
  int          lat = 1;
  int          checks = 0;
  int          errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs, check request side, then advance the reference model across the edge.
  task automatic step(input bit r, input bit h, input bit f, input logic [31:0] tgt, input bit rdy);
    bit   v;
    bit   exp_req;
    req_t e;
    @(negedge clk);
    cyc++;
    v = !r && (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    rst        = r;
    hazard     = h;
    flush      = f;
    target     = tgt;
    imem_ready = rdy;
    imem_valid = v;
    imem_data  = v ? (pend_q[0].addr ^ KEY) : $urandom;
    #1;
    exp_req = !r && !f && ((sb_q.size() + pend_q.size()) < DEPTH);
    check32("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (!r) check32("imem_addr", imem_addr, next_pc);
    if (r) begin
      sb_q.delete();
      pend_q.delete();
      next_pc = RESET_PC;
      epoch++;
    end else begin
      if (!h && !f && (sb_q.size() > 0)) void'(sb_q.pop_front());
      if (v) begin
        e = pend_q.pop_front();
        if ((e.epoch == epoch) && !f) sb_q.push_back('{pc: e.addr, instr: e.addr ^ KEY});
      end
      if (f) begin
        sb_q.delete();
        next_pc = {tgt[31:2], 2'b00};
        epoch++;
      end else if (exp_req && rdy) begin
        pend_q.push_back('{addr: next_pc, epoch: epoch, due: cyc + lat});
        next_pc = next_pc + 32'd4;
      end
    end
  endtask

  // Monitor: after every edge the DUT head must match the scoreboard head, or be a bubble.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() == 0) begin
        check32("bubble", {31'b0, bubble}, 32'd1);
        check32("pc_bubble", pc, 32'h0);
        check32("instr_bubble", instr, 32'h0);
      end else begin
        check32("bubble", {31'b0, bubble}, 32'd0);
        check32("pc", pc, sb_q[0].pc);
        check32("instr", instr, sb_q[0].instr);
      end
    end
  end

  initial begin
    bit done;
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    lat = 1;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);

    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

    lat = 3;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h0000_0103, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);

    done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      if ((pend_q.size() > 0) && (pend_q[0].due <= cyc + 1)) begin
        step(0, 1, 1, 32'h0000_0200, 1);
        done = 1;
      end else begin
        step(0, 1, 0, 0, 1);
      end
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);

    lat = 1;
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);

    for (int i = 0; i < 2500; i++) begin
      if (i % 50 == 0) lat = int'($urandom_range(1, 4));
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 5),
           $urandom,
           ($urandom_range(0, 99) < 70));
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
